// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ID->EX ALU issue stage: ALU op codes, RV32 major
// opcodes, funct3/funct7 fields and the decoder's result bundle.
package alu_defs_pkg;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_OR     = 5'b00010;
  localparam logic [4:0] ALU_XOR    = 5'b00011;
  localparam logic [4:0] ALU_AND    = 5'b00100;
  localparam logic [4:0] ALU_SRL    = 5'b00101;
  localparam logic [4:0] ALU_SLL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_MUL    = 5'b01000;
  localparam logic [4:0] ALU_MULH   = 5'b01001;
  localparam logic [4:0] ALU_MULHU  = 5'b01010;
  localparam logic [4:0] ALU_MULHSU = 5'b01011;
  localparam logic [4:0] ALU_DIV    = 5'b01100;
  localparam logic [4:0] ALU_DIVU   = 5'b01101;
  localparam logic [4:0] ALU_REM    = 5'b01110;
  localparam logic [4:0] ALU_REMU   = 5'b01111;
  localparam logic [4:0] ALU_SLT    = 5'b10000;
  localparam logic [4:0] ALU_FWD    = 5'b10001;
  localparam logic [4:0] ALU_SLTU   = 5'b10010;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_MULH    = 3'b001;
  localparam logic [2:0] F3_MULHSU  = 3'b010;
  localparam logic [2:0] F3_MULHU   = 3'b011;
  localparam logic [2:0] F3_DIV     = 3'b100;
  localparam logic [2:0] F3_DIVU    = 3'b101;
  localparam logic [2:0] F3_REM     = 3'b110;
  localparam logic [2:0] F3_REMU    = 3'b111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MEXT    = 7'b0000001;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
  typedef enum logic       {OP2_RS2, OP2_IMM}          op2_sel_e;
  typedef enum logic       {ST_IDLE, ST_HOLD}          issue_state_e;

  typedef struct packed {
    logic [4:0]  alu_op;
    op1_sel_e    op1_sel;
    op2_sel_e    op2_sel;
    logic [31:0] imm;
    logic        we;
    logic        illegal;
  } dec_t;

  function automatic logic is_div_class(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_op_issue_if.sv
// Issue-stage bus: instruction/operand input handshake toward the decoder and
// the registered ALU triple toward execute.
interface alu_op_issue_if #(
  parameter int XLEN = 32
) ();
  logic            IN_VALID;
  logic            IN_READY;
  logic [31:0]     INSTRUCTION;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] RS1_DATA;
  logic [XLEN-1:0] RS2_DATA;
  logic            STALL;
  logic            FLUSH;
  logic [4:0]      ALU_OPCODE;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic [4:0]      RD_ADDR;
  logic            REG_WRITE_EN;
  logic            OUT_VALID;
  logic            ILLEGAL;

  modport master (
    output IN_VALID, INSTRUCTION, PC, RS1_DATA, RS2_DATA, STALL, FLUSH,
    input  IN_READY, ALU_OPCODE, DATA1, DATA2, RD_ADDR, REG_WRITE_EN, OUT_VALID, ILLEGAL
  );

  modport slave (
    input  IN_VALID, INSTRUCTION, PC, RS1_DATA, RS2_DATA, STALL, FLUSH,
    output IN_READY, ALU_OPCODE, DATA1, DATA2, RD_ADDR, REG_WRITE_EN, OUT_VALID, ILLEGAL
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32IM decoder: instruction word -> ALU op, operand selects,
// sign-extended immediate, register-write enable and illegal flag.
module alu_op_decode
  import alu_defs_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       writes_rd;

  logic signed [31:0] i_imm;
  logic signed [31:0] s_imm;
  logic        [31:0] u_imm;
  logic        [31:0] shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  assign i_imm  = {{20{instr[31]}}, instr[31:20]};
  assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign u_imm  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_ADD;
    dec.op1_sel = OP1_RS1;
    dec.op2_sel = OP2_RS2;
    writes_rd   = 1'b0;

    case (opcode)
      OPC_OP: begin
        writes_rd = 1'b1;
        case (funct7)
          F7_BASE: begin
            case (funct3)
              F3_ADD_SUB: dec.alu_op = ALU_ADD;
              F3_SLL:     dec.alu_op = ALU_SLL;
              F3_SLT:     dec.alu_op = ALU_SLT;
              F3_SLTU:    dec.alu_op = ALU_SLTU;
              F3_XOR:     dec.alu_op = ALU_XOR;
              F3_SR:      dec.alu_op = ALU_SRL;
              F3_OR:      dec.alu_op = ALU_OR;
              default:    dec.alu_op = ALU_AND;
            endcase
          end
          F7_ALT: begin
            case (funct3)
              F3_ADD_SUB: dec.alu_op  = ALU_SUB;
              F3_SR:      dec.alu_op  = ALU_SRA;
              default:    dec.illegal = 1'b1;
            endcase
          end
          F7_MEXT: begin
            case (funct3)
              F3_MUL:    dec.alu_op = ALU_MUL;
              F3_MULH:   dec.alu_op = ALU_MULH;
              F3_MULHSU: dec.alu_op = ALU_MULHSU;
              F3_MULHU:  dec.alu_op = ALU_MULHU;
              F3_DIV:    dec.alu_op = ALU_DIV;
              F3_DIVU:   dec.alu_op = ALU_DIVU;
              F3_REM:    dec.alu_op = ALU_REM;
              default:   dec.alu_op = ALU_REMU;
            endcase
          end
          default: dec.illegal = 1'b1;
        endcase
      end

      OPC_OP_IMM: begin
        writes_rd   = 1'b1;
        dec.op2_sel = OP2_IMM;
        dec.imm     = i_imm;
        case (funct3)
          F3_ADD_SUB: dec.alu_op = ALU_ADD;
          F3_SLT:     dec.alu_op = ALU_SLT;
          F3_SLTU:    dec.alu_op = ALU_SLTU;
          F3_XOR:     dec.alu_op = ALU_XOR;
          F3_OR:      dec.alu_op = ALU_OR;
          F3_AND:     dec.alu_op = ALU_AND;
          F3_SLL: begin
            dec.alu_op  = ALU_SLL;
            dec.imm     = shamt;
            dec.illegal = (funct7 != F7_BASE);
          end
          default: begin
            // imm[10] (instr[30]) picks arithmetic vs logical right shift
            dec.alu_op  = instr[30] ? ALU_SRA : ALU_SRL;
            dec.imm     = shamt;
            dec.illegal = ({instr[31], instr[29:25]} != 6'b0);
          end
        endcase
      end

      OPC_LUI: begin
        writes_rd   = 1'b1;
        dec.alu_op  = ALU_FWD;
        dec.op1_sel = OP1_ZERO;
        dec.op2_sel = OP2_IMM;
        dec.imm     = u_imm;
      end

      OPC_AUIPC: begin
        writes_rd   = 1'b1;
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_IMM;
        dec.imm     = u_imm;
      end

      OPC_LOAD: begin
        writes_rd   = 1'b1;
        dec.op2_sel = OP2_IMM;
        dec.imm     = i_imm;
        dec.illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end

      OPC_STORE: begin
        dec.op2_sel = OP2_IMM;
        dec.imm     = s_imm;
        dec.illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
      end

      OPC_BRANCH: begin
        dec.alu_op  = ALU_SUB;
        dec.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end

      OPC_JAL, OPC_JALR: begin
        // Link value PC+4; target arithmetic lives in the branch unit
        writes_rd   = 1'b1;
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_IMM;
        dec.imm     = 32'd4;
        dec.illegal = (opcode == OPC_JALR) && (funct3 != 3'b000);
      end

      default: dec.illegal = 1'b1;
    endcase

    dec.we = writes_rd && (rd != 5'd0) && !dec.illegal;
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID->EX issue stage: decodes, selects ALU operands and registers them, holding
// divide-class ops for DIV_HOLD cycles to cover the divider's multi-cycle path.
module alu_op_issue
  import alu_defs_pkg::*;
#(
  parameter int DIV_HOLD = 4,
  parameter int XLEN     = 32
) (
  input logic           CLK,
  input logic           RESET,
  alu_op_issue_if.slave bus
);

  localparam int              CNT_W    = $clog2(DIV_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_HOLD - 1);

  dec_t               dec;
  logic signed [31:0] imm_s;
  logic [XLEN-1:0]    imm_x;
  logic [XLEN-1:0]    op1;
  logic [XLEN-1:0]    op2;
  logic               in_ready;
  logic               accept;

  issue_state_e       state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [4:0]         alu_op_q,    alu_op_d;
  logic [XLEN-1:0]    data1_q,     data1_d;
  logic [XLEN-1:0]    data2_q,     data2_d;
  logic [4:0]         rd_q,        rd_d;
  logic               we_q,        we_d;
  logic               out_valid_q, out_valid_d;
  logic               illegal_q,   illegal_d;

  alu_op_decode u_decode (
    .instr (bus.INSTRUCTION),
    .dec   (dec)
  );

  assign imm_s = dec.imm;
  assign imm_x = XLEN'(imm_s);

  always_comb begin
    op1 = bus.RS1_DATA;
    case (dec.op1_sel)
      OP1_PC:   op1 = bus.PC;
      OP1_ZERO: op1 = '0;
      default:  op1 = bus.RS1_DATA;
    endcase
    op2 = (dec.op2_sel == OP2_IMM) ? imm_x : bus.RS2_DATA;
  end

  assign in_ready = (state_q == ST_IDLE) && !bus.STALL;
  assign accept   = bus.IN_VALID && in_ready && !bus.FLUSH;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    rd_d        = rd_q;
    we_d        = we_q;
    out_valid_d = out_valid_q;
    illegal_d   = illegal_q;

    if (bus.FLUSH) begin
      out_valid_d = 1'b0;
      we_d        = 1'b0;
      illegal_d   = 1'b0;
      state_d     = ST_IDLE;
      cnt_d       = '0;
    end else if (!bus.STALL) begin
      case (state_q)
        ST_IDLE: begin
          illegal_d   = 1'b0;
          out_valid_d = 1'b0;
          we_d        = 1'b0;
          if (accept) begin
            if (dec.illegal) begin
              illegal_d = 1'b1;
            end else begin
              alu_op_d    = dec.alu_op;
              data1_d     = op1;
              data2_d     = op2;
              rd_d        = bus.INSTRUCTION[11:7];
              we_d        = dec.we;
              out_valid_d = 1'b1;
              if (is_div_class(dec.alu_op)) begin
                state_d = ST_HOLD;
                cnt_d   = CNT_LOAD;
              end
            end
          end
        end
        default: begin
          // Divide result is consumed on the edge that leaves HOLD
          if (cnt_q == '0) begin
            out_valid_d = 1'b0;
            we_d        = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_op_q    <= ALU_ADD;
      data1_q     <= '0;
      data2_q     <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.IN_READY     = in_ready;
  assign bus.ALU_OPCODE   = alu_op_q;
  assign bus.DATA1        = data1_q;
  assign bus.DATA2        = data2_q;
  assign bus.RD_ADDR      = rd_q;
  assign bus.REG_WRITE_EN = we_q;
  assign bus.OUT_VALID    = out_valid_q;
  assign bus.ILLEGAL      = illegal_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue: directed instructions push expected ALU
// triples; a negedge monitor pops one entry per live or illegal output cycle.
module tb_alu_op_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_issue_if #(.XLEN(32)) bus ();

  alu_op_issue #(.DIV_HOLD(4), .XLEN(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
    bit          chk_d1;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [4:0] op, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [4:0] rd, input logic we,
                      input bit chk_d1, input bit chk_rd);
    exp_t e;
    e.name = nm; e.op = op; e.d1 = d1; e.d2 = d2; e.rd = rd; e.we = we;
    e.illegal = 1'b0; e.chk_d1 = chk_d1; e.chk_rd = chk_rd;
    sb.push_back(e);
  endtask

  task automatic push_illegal(input string nm);
    exp_t e;
    e.name = nm; e.op = '0; e.d1 = '0; e.d2 = '0; e.rd = '0; e.we = 1'b0;
    e.illegal = 1'b1; e.chk_d1 = 1'b0; e.chk_rd = 1'b0;
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per cycle with OUT_VALID or ILLEGAL
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.OUT_VALID || bus.ILLEGAL)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output op=%b valid=%b illegal=%b d1=0x%08h d2=0x%08h",
                 bus.ALU_OPCODE, bus.OUT_VALID, bus.ILLEGAL, bus.DATA1, bus.DATA2);
      end else begin
        e = sb.pop_front();
        if (e.illegal) begin
          chk({e.name, "_illegal"}, 32'(bus.ILLEGAL), 32'd1);
          chk({e.name, "_valid"},   32'(bus.OUT_VALID), 32'd0);
          chk({e.name, "_we"},      32'(bus.REG_WRITE_EN), 32'd0);
        end else begin
          chk({e.name, "_valid"},   32'(bus.OUT_VALID), 32'd1);
          chk({e.name, "_illegal"}, 32'(bus.ILLEGAL), 32'd0);
          chk({e.name, "_op"},      32'(bus.ALU_OPCODE), 32'(e.op));
          if (e.chk_d1) chk({e.name, "_data1"}, bus.DATA1, e.d1);
          chk({e.name, "_data2"},   bus.DATA2, e.d2);
          if (e.chk_rd) chk({e.name, "_rd"}, 32'(bus.RD_ADDR), 32'(e.rd));
          chk({e.name, "_we"},      32'(bus.REG_WRITE_EN), 32'(e.we));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.IN_VALID    = 1'b1;
    bus.INSTRUCTION = instr;
    bus.PC          = pc;
    bus.RS1_DATA    = rs1;
    bus.RS2_DATA    = rs2;
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_op"},       32'(bus.ALU_OPCODE), 32'd0);
    chk({nm, "_data1"},    bus.DATA1, 32'd0);
    chk({nm, "_data2"},    bus.DATA2, 32'd0);
    chk({nm, "_rd"},       32'(bus.RD_ADDR), 32'd0);
    chk({nm, "_we"},       32'(bus.REG_WRITE_EN), 32'd0);
    chk({nm, "_valid"},    32'(bus.OUT_VALID), 32'd0);
    chk({nm, "_illegal"},  32'(bus.ILLEGAL), 32'd0);
    chk({nm, "_in_ready"}, 32'(bus.IN_READY), 32'd1);
  endtask

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_SRA = 5'b00111,
                         OP_DIV = 5'b01100, OP_FWD = 5'b10001;

  initial begin
    bus.IN_VALID = 1'b0; bus.INSTRUCTION = '0; bus.PC = '0;
    bus.RS1_DATA = '0;   bus.RS2_DATA = '0;    bus.STALL = 1'b0; bus.FLUSH = 1'b0;

    repeat (3) tick();
    check_reset_state("reset");
    rst = 1'b0;

    // ADD x3,x1,x2
    drive(32'h002081B3, 32'h100, 32'd10, 32'd20);
    push("add", OP_ADD, 32'd10, 32'd20, 5'd3, 1'b1, 1, 1);
    tick();

    // SUB then ADDI x1,x0,-1 back-to-back
    drive(32'h402081B3, 32'h104, 32'd50, 32'd8);
    push("sub", OP_SUB, 32'd50, 32'd8, 5'd3, 1'b1, 1, 1);
    tick();
    drive(32'hFFF00093, 32'h108, 32'd0, 32'd0);
    push("addi", OP_ADD, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1, 1, 1);
    tick();
    bus.IN_VALID = 1'b0;
    tick();
    chk("bubble_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("bubble_we",    32'(bus.REG_WRITE_EN), 32'd0);
    chk("bubble_data2", bus.DATA2, 32'hFFFFFFFF);

    // DIV x5,x6,x7 held 4 cycles; following ADD waits in IN_VALID
    drive(32'h027342B3, 32'h10C, 32'd100, 32'd7);
    for (int i = 0; i < 4; i++) push("div", OP_DIV, 32'd100, 32'd7, 5'd5, 1'b1, 1, 1);
    tick();
    drive(32'h002081B3, 32'h110, 32'd1, 32'd2);
    push("add_after_div", OP_ADD, 32'd1, 32'd2, 5'd3, 1'b1, 1, 1);
    chk("div_ready0", 32'(bus.IN_READY), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("div_hold_ready", 32'(bus.IN_READY), 32'd0);
      chk("div_hold_valid", 32'(bus.OUT_VALID), 32'd1);
    end
    tick();
    chk("div_exit_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("div_exit_ready", 32'(bus.IN_READY), 32'd1);
    tick();
    bus.IN_VALID = 1'b0;
    tick();

    // Decode sweep: SW, BEQ, JAL, SRAI, AUIPC
    drive(32'h0020A423, 32'h200, 32'h1000, 32'hAA);
    push("sw", OP_ADD, 32'h1000, 32'd8, 5'd0, 1'b0, 1, 0);
    tick();
    drive(32'h00208463, 32'h204, 32'd5, 32'd5);
    push("beq", OP_SUB, 32'd5, 32'd5, 5'd0, 1'b0, 1, 0);
    tick();
    drive(32'h000000EF, 32'h208, 32'd77, 32'd88);
    push("jal", OP_ADD, 32'h208, 32'd4, 5'd1, 1'b1, 1, 1);
    tick();
    drive(32'h4030D093, 32'h20C, 32'h80000000, 32'd0);
    push("srai", OP_SRA, 32'h80000000, 32'd3, 5'd1, 1'b1, 1, 1);
    tick();
    drive(32'h00001117, 32'h300, 32'd9, 32'd9);
    push("auipc", OP_ADD, 32'h300, 32'h1000, 5'd2, 1'b1, 1, 1);
    tick();
    bus.IN_VALID = 1'b0;
    tick();

    // DIV with a 2-cycle STALL mid-HOLD: 6 live cycles
    drive(32'h027342B3, 32'h400, 32'd200, 32'd3);
    for (int i = 0; i < 6; i++) push("div_stall", OP_DIV, 32'd200, 32'd3, 5'd5, 1'b1, 1, 1);
    tick();
    bus.IN_VALID = 1'b0;
    tick();
    bus.STALL = 1'b1;
    chk("stall_ready", 32'(bus.IN_READY), 32'd0);
    repeat (2) tick();
    bus.STALL = 1'b0;
    repeat (2) tick();
    chk("div_stall_last_valid", 32'(bus.OUT_VALID), 32'd1);
    tick();
    chk("div_stall_exit_valid", 32'(bus.OUT_VALID), 32'd0);

    // FLUSH during HOLD
    drive(32'h027342B3, 32'h500, 32'd9, 32'd9);
    push("div_flush", OP_DIV, 32'd9, 32'd9, 5'd5, 1'b1, 1, 1);
    tick();
    bus.IN_VALID = 1'b0;
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    chk("flush_hold_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("flush_hold_we",    32'(bus.REG_WRITE_EN), 32'd0);
    chk("flush_hold_ready", 32'(bus.IN_READY), 32'd1);

    // FLUSH with an incoming instruction: dropped
    drive(32'h002081B3, 32'h504, 32'd3, 32'd4);
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    bus.IN_VALID = 1'b0;
    chk("flush_in_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("flush_in_we",    32'(bus.REG_WRITE_EN), 32'd0);
    chk("flush_in_ready", 32'(bus.IN_READY), 32'd1);

    // LUI, then an illegal word
    drive(32'h123450B7, 32'h600, 32'hDEAD, 32'hBEEF);
    push("lui", OP_FWD, 32'd0, 32'h12345000, 5'd1, 1'b1, 0, 1);
    tick();
    drive(32'hFFFFFFFF, 32'h604, 32'd0, 32'd0);
    push_illegal("illegal_word");
    tick();
    bus.IN_VALID = 1'b0;
    tick();
    chk("illegal_one_cycle", 32'(bus.ILLEGAL), 32'd0);
    chk("illegal_after_valid", 32'(bus.OUT_VALID), 32'd0);

    // RESET mid-HOLD
    drive(32'h027342B3, 32'h700, 32'd40, 32'd5);
    push("div_reset", OP_DIV, 32'd40, 32'd5, 5'd5, 1'b1, 1, 1);
    tick();
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    check_reset_state("reset_mid_hold");
    rst = 1'b0;
    repeat (2) tick();
    chk("post_reset_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("post_reset_ready", 32'(bus.IN_READY), 32'd1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
